// File: rtl/control_barrera.sv
// Shared entry/exit lane sequencer: arbitrates requests, drives barriers,
// confirms each crossing and pulses z1/z2 into the occupancy counter.
module control_barrera #(
    parameter int T_ABIERTO = 50,
    parameter int T_CIERRE  = 4,
    parameter int CAPACIDAD = 7,
    parameter int CW        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ent,
    input  logic       req_sal,
    input  logic       paso,
    input  logic       lleno,
    input  logic [2:0] c,
    output logic       bar_ent,
    output logic       bar_sal,
    output logic       z1,
    output logic       z2,
    output logic       ocupado,
    output logic       error
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ABRE_ENT = 4'd1,
        S_ABRE_SAL = 4'd2,
        S_PASO_ENT = 4'd3,
        S_PASO_SAL = 4'd4,
        S_FIN_ENT  = 4'd5,
        S_FIN_SAL  = 4'd6,
        S_TMO      = 4'd7,
        S_CIERRE   = 4'd8
    } state_t;

    localparam logic [CW-1:0] ABRE_LAST   = CW'(T_ABIERTO - 1);
    localparam logic [CW-1:0] CIERRE_LAST = CW'(T_CIERRE - 1);
    localparam logic [3:0]    CAP         = 4'(CAPACIDAD);

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          ult_q, ult_d;
    logic          ok_ent, ok_sal;

    assign ok_ent = req_ent & ~lleno & ({1'b0, c} < CAP);
    assign ok_sal = req_sal & (c != 3'd0);

    always_comb begin
        state_d = state_q;
        ult_d   = ult_q;
        case (state_q)
            S_IDLE: begin
                // ult=1 means exit was served last, so entry wins a tie
                if (ok_ent && (!ok_sal || ult_q)) begin
                    state_d = S_ABRE_ENT;
                    ult_d   = 1'b0;
                end else if (ok_sal) begin
                    state_d = S_ABRE_SAL;
                    ult_d   = 1'b1;
                end
            end
            S_ABRE_ENT: begin
                if (paso)
                    state_d = S_PASO_ENT;
                else if (timer_q == ABRE_LAST)
                    state_d = S_TMO;
            end
            S_ABRE_SAL: begin
                if (paso)
                    state_d = S_PASO_SAL;
                else if (timer_q == ABRE_LAST)
                    state_d = S_TMO;
            end
            S_PASO_ENT: if (!paso) state_d = S_FIN_ENT;
            S_PASO_SAL: if (!paso) state_d = S_FIN_SAL;
            S_FIN_ENT:  state_d = S_CIERRE;
            S_FIN_SAL:  state_d = S_CIERRE;
            S_TMO:      state_d = S_CIERRE;
            S_CIERRE:   if (timer_q == CIERRE_LAST) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == S_ABRE_ENT || state_q == S_ABRE_SAL
                 || state_q == S_CIERRE)
            timer_d = timer_q + CW'(1);
    end

    always_comb begin
        bar_ent = 1'b0;
        bar_sal = 1'b0;
        z1      = 1'b0;
        z2      = 1'b0;
        error   = 1'b0;
        ocupado = (state_q != S_IDLE);
        case (state_q)
            S_ABRE_ENT, S_PASO_ENT: bar_ent = 1'b1;
            S_ABRE_SAL, S_PASO_SAL: bar_sal = 1'b1;
            S_FIN_ENT:              z1      = 1'b1;
            S_FIN_SAL:              z2      = 1'b1;
            S_TMO:                  error   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            ult_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ult_q   <= ult_d;
        end
    end

endmodule

// File: tb/tb_control_barrera.sv
// Directed bench for control_barrera: per-cycle vector table plus
// hand sequences for tie, timeout, stuck sensor and mid-crossing reset.
module tb_control_barrera;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_ent, req_sal, paso, lleno;
    logic [2:0] c;
    logic       bar_ent, bar_sal, z1, z2, ocupado, error;

    int total  = 0;
    int passed = 0;
    int overlap = 0;
    int multi   = 0;

    control_barrera #(
        .T_ABIERTO(8),
        .T_CIERRE (2),
        .CAPACIDAD(7),
        .CW       (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_ent(req_ent),
        .req_sal(req_sal),
        .paso   (paso),
        .lleno  (lleno),
        .c      (c),
        .bar_ent(bar_ent),
        .bar_sal(bar_sal),
        .z1     (z1),
        .z2     (z2),
        .ocupado(ocupado),
        .error  (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bar_ent && bar_sal) overlap++;
        if (int'(z1) + int'(z2) + int'(error) > 1) multi++;
    end

    typedef struct {
        logic       re;
        logic       rs;
        logic       pa;
        logic       ll;
        logic [2:0] cc;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic re, logic rs, logic pa, logic ll,
                                logic [2:0] cc, logic [5:0] exp);
        vec_t v;
        v.re = re; v.rs = rs; v.pa = pa; v.ll = ll; v.cc = cc; v.exp = exp;
        return v;
    endfunction

    // {bar_ent, bar_sal, z1, z2, ocupado, error}
    function automatic logic [5:0] outs();
        return {bar_ent, bar_sal, z1, z2, ocupado, error};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(logic re, logic rs, logic pa, logic ll,
                          logic [2:0] cc);
        req_ent = re; req_sal = rs; paso = pa; lleno = ll; c = cc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // One grant under held tie requests; checks side and its pulse
    task automatic tie_grant(logic exp_ent, string name);
        int n;
        n = 0;
        while (!(bar_ent || bar_sal) && n < 12) begin
            step();
            n++;
        end
        chk({name, "_side"}, {31'd0, bar_ent}, {31'd0, exp_ent});
        paso = 1'b1;
        step();
        paso = 1'b0;
        step();
        chk({name, "_z"}, {30'd0, z1, z2}, exp_ent ? 32'd2 : 32'd1);
    endtask

    initial begin
        int cnt, bad, zc, errs;
        set_in(0, 0, 0, 0, 3'd3);
        reset = 1'b1;
        step();
        chk("reset_outs", {26'd0, outs()}, 32'd0);
        reset = 1'b0;

        // single entry, then full/empty refusal and entry at c=0
        tbl.push_back(mk(0, 0, 0, 0, 3'd3, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 0, 3'd3, 6'b100010));
        tbl.push_back(mk(0, 0, 1, 0, 3'd3, 6'b100010));
        tbl.push_back(mk(0, 0, 1, 0, 3'd3, 6'b100010));
        tbl.push_back(mk(0, 0, 1, 0, 3'd3, 6'b100010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd3, 6'b001010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd3, 6'b000010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd3, 6'b000010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd3, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 1, 3'd7, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 1, 3'd7, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 0, 3'd7, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 1, 3'd3, 6'b000000));
        tbl.push_back(mk(0, 1, 0, 0, 3'd0, 6'b000000));
        tbl.push_back(mk(0, 1, 0, 0, 3'd0, 6'b000000));
        tbl.push_back(mk(1, 0, 0, 0, 3'd0, 6'b100010));
        tbl.push_back(mk(0, 0, 1, 0, 3'd1, 6'b100010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd1, 6'b001010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd1, 6'b000010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd1, 6'b000010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd1, 6'b000000));
        tbl.push_back(mk(0, 1, 0, 0, 3'd6, 6'b010010));
        tbl.push_back(mk(0, 0, 1, 0, 3'd6, 6'b010010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd6, 6'b000110));
        tbl.push_back(mk(0, 0, 0, 0, 3'd6, 6'b000010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd6, 6'b000010));
        tbl.push_back(mk(0, 0, 0, 0, 3'd6, 6'b000000));

        foreach (tbl[i]) begin
            set_in(tbl[i].re, tbl[i].rs, tbl[i].pa, tbl[i].ll, tbl[i].cc);
            step();
            chk($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp});
        end

        // tie: entry first after reset, then alternate
        set_in(0, 0, 0, 0, 3'd3);
        do_reset();
        req_ent = 1'b1;
        req_sal = 1'b1;
        tie_grant(1'b1, "tie1");
        tie_grant(1'b0, "tie2");
        tie_grant(1'b1, "tie3");
        tie_grant(1'b0, "tie4");
        set_in(0, 0, 0, 0, 3'd3);
        repeat (4) step();
        chk("tie_idle", {31'd0, ocupado}, 32'd0);

        // timeout: barrier open exactly 8 cycles
        do_reset();
        req_ent = 1'b1;
        step();
        req_ent = 1'b0;
        cnt = 0;
        zc = 0;
        while (bar_ent && cnt < 20) begin
            cnt++;
            step();
            if (z1) zc++;
        end
        chk("tmo_open_cycles", cnt, 32'd8);
        chk("tmo_error", {26'd0, outs()}, 32'b000011);
        step();
        chk("tmo_error_once", {31'd0, error}, 32'd0);
        step();
        chk("tmo_guard2", {31'd0, ocupado}, 32'd1);
        step();
        chk("tmo_idle", {31'd0, ocupado}, 32'd0);
        chk("tmo_no_z1", zc, 32'd0);

        // stuck paso during exit
        set_in(0, 1, 0, 0, 3'd3);
        step();
        chk("stuck_grant", {26'd0, outs()}, 32'b010010);
        req_sal = 1'b0;
        paso = 1'b1;
        bad = 0;
        errs = 0;
        repeat (20) begin
            step();
            if (!bar_sal) bad++;
            if (error) errs++;
        end
        chk("stuck_bar_held", bad, 32'd0);
        chk("stuck_no_error", errs, 32'd0);
        paso = 1'b0;
        step();
        chk("stuck_z2", {26'd0, outs()}, 32'b000110);
        zc = 0;
        repeat (4) begin
            step();
            if (z2) zc++;
        end
        chk("stuck_z2_once", zc, 32'd0);

        // reset while vehicle is in the lane
        set_in(1, 0, 0, 0, 3'd3);
        step();
        req_ent = 1'b0;
        paso = 1'b1;
        step();
        chk("rst_in_paso", {26'd0, outs()}, 32'b100010);
        reset = 1'b1;
        step();
        chk("rst_outs", {26'd0, outs()}, 32'd0);
        reset = 1'b0;
        paso = 1'b0;
        step();
        chk("rst_no_z1", {26'd0, outs()}, 32'd0);
        req_ent = 1'b1;
        step();
        chk("rst_regrant", {26'd0, outs()}, 32'b100010);
        set_in(0, 0, 0, 0, 3'd3);
        repeat (12) step();
        chk("end_idle", {31'd0, ocupado}, 32'd0);

        chk("bars_never_overlap", overlap, 32'd0);
        chk("pulses_exclusive", multi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
